// File: rtl/vdp_pkg.sv
// vdp_pkg -- shared constants and types for the VDP CPU port.
//   Port numbers of the data/control IO ports, status byte bit positions,
//   VRAM address width, register count, the control FSM state type and a
//   wrap-around VRAM address increment helper.
package vdp_pkg;

  localparam logic [7:0] PORT_DATA = 8'h98;
  localparam logic [7:0] PORT_CTRL = 8'h99;

  // Status byte layout: {F, 5S, C, fifth_num[4:0]}
  localparam int STAT_F  = 7;
  localparam int STAT_5S = 6;
  localparam int STAT_C  = 5;

  localparam int VRAM_AW  = 14;
  localparam int NUM_REGS = 8;

  typedef enum logic {
    ST_FIRST  = 1'b0,
    ST_SECOND = 1'b1
  } ctrl_state_e;

  // 14-bit address increment; 0x3FFF wraps to 0x0000 by truncation.
  function automatic logic [VRAM_AW-1:0] vram_addr_inc(input logic [VRAM_AW-1:0] a);
    return a + 14'd1;
  endfunction

endpackage

// File: rtl/vdp_status.sv
// vdp_status -- VDP status flags and interrupt output.
//   clk, reset        : clock, synchronous active-high reset
//   frame_end         : sets F (vertical blank)
//   spr_coll          : sets C (sprite collision)
//   spr_fifth/_num    : sets 5S and captures the sprite number while 5S=0
//   clr               : status-read clear of F/5S/C; a set pulse wins
//   int_en            : R1[5], frame interrupt enable
//   status            : {F,5S,C,fifth_num}
//   n_int             : active-low interrupt, ~(F & int_en)
module vdp_status
  import vdp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_end,
  input  logic       spr_coll,
  input  logic       spr_fifth,
  input  logic [4:0] spr_fifth_num,
  input  logic       clr,
  input  logic       int_en,
  output logic [7:0] status,
  output logic       n_int
);

  logic       f_q, f_d;
  logic       c_q, c_d;
  logic       s5_q, s5_d;
  logic [4:0] num_q, num_d;

  // Next-state flags: a set pulse in the clear clock keeps the flag set.
  always_comb begin
    f_d   = frame_end | (f_q & ~clr);
    c_d   = spr_coll | (c_q & ~clr);
    s5_d  = spr_fifth | (s5_q & ~clr);
    // The sprite number is frozen while 5S is already set.
    if (spr_fifth && !s5_q) begin
      num_d = spr_fifth_num;
    end else begin
      num_d = num_q;
    end
  end

  // Flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_q   <= 1'b0;
      c_q   <= 1'b0;
      s5_q  <= 1'b0;
      num_q <= 5'd0;
    end else begin
      f_q   <= f_d;
      c_q   <= c_d;
      s5_q  <= s5_d;
      num_q <= num_d;
    end
  end

  // Status byte assembly and interrupt output.
  always_comb begin
    status          = 8'h00;
    status[STAT_F]  = f_q;
    status[STAT_5S] = s5_q;
    status[STAT_C]  = c_q;
    status[4:0]     = num_q;
    n_int           = ~(f_q & int_en);
  end

endmodule

// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port -- CPU-facing IO port of a TMS9918-style VDP.
//   clk, reset              : clock, synchronous active-high reset
//   ce                      : CPU clock-enable pulse
//   io_addr, n_io_wr,
//   n_io_rd, din            : CPU IO bus (ports 0x98 data, 0x99 control/status)
//   dout                    : read data (status at 0x99, read buffer otherwise)
//   vram_addr/_wdata/_we/_re: VRAM access toward the video block
//   vram_rdata, vram_rvalid : VRAM read return, 1 clk after vram_re
//   frame_end, spr_coll,
//   spr_fifth, spr_fifth_num: status flag sources
//   regs                    : R0..R7, Rn at [8n+7:8n]
//   n_int                   : active-low interrupt
module vdp_cpu_port
  import vdp_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [7:0]            io_addr,
  input  logic                  n_io_wr,
  input  logic                  n_io_rd,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic [VRAM_AW-1:0]    vram_addr,
  output logic [7:0]            vram_wdata,
  output logic                  vram_we,
  output logic                  vram_re,
  input  logic [7:0]            vram_rdata,
  input  logic                  vram_rvalid,
  input  logic                  frame_end,
  input  logic                  spr_coll,
  input  logic                  spr_fifth,
  input  logic [4:0]            spr_fifth_num,
  output logic [8*NUM_REGS-1:0] regs,
  output logic                  n_int
);

  ctrl_state_e                  state_q;
  logic                         wr_prev_q;
  logic                         rd_prev_q;
  logic [7:0]                   latch_q;
  logic [VRAM_AW-1:0]           addr_q;
  logic [7:0]                   rbuf_q;
  logic [7:0]                   wdata_q;
  logic                         we_q;
  logic                         re_q;
  logic                         rv_expect_q;
  logic [NUM_REGS-1:0][7:0]     regs_q;

  logic                         port_sel_d;
  logic                         is_ctrl_d;
  logic                         wr_ev_d;
  logic                         rd_ev_d;
  logic                         wr_data_ev_d;
  logic                         wr_ctrl_ev_d;
  logic                         rd_data_ev_d;
  logic                         rd_stat_ev_d;
  logic [7:0]                   status_d;

  // Access event decode: one event per IO cycle, on the first ce the strobe is low.
  always_comb begin
    port_sel_d   = (io_addr == PORT_DATA) || (io_addr == PORT_CTRL);
    is_ctrl_d    = (io_addr == PORT_CTRL);
    wr_ev_d      = ce & ~n_io_wr & wr_prev_q & port_sel_d;
    rd_ev_d      = ce & ~n_io_rd & rd_prev_q & port_sel_d;
    wr_data_ev_d = wr_ev_d & ~is_ctrl_d;
    wr_ctrl_ev_d = wr_ev_d & is_ctrl_d;
    rd_data_ev_d = rd_ev_d & ~is_ctrl_d;
    rd_stat_ev_d = rd_ev_d & is_ctrl_d;
  end

  // Control FSM, VRAM access sequencing, registers and read buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FIRST;
      wr_prev_q   <= 1'b1;
      rd_prev_q   <= 1'b1;
      latch_q     <= 8'h00;
      addr_q      <= '0;
      rbuf_q      <= 8'h00;
      wdata_q     <= 8'h00;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      rv_expect_q <= 1'b0;
      regs_q      <= '0;
    end else begin
      if (ce) begin
        wr_prev_q <= n_io_wr;
        rd_prev_q <= n_io_rd;
      end

      we_q        <= 1'b0;
      re_q        <= 1'b0;
      // Only a read issued since the last reset may load the read buffer.
      rv_expect_q <= re_q;

      // Post-increment after every VRAM access; ce spacing keeps this
      // away from the next address load.
      if (we_q || re_q) begin
        addr_q <= vram_addr_inc(addr_q);
      end

      if (vram_rvalid && rv_expect_q) begin
        rbuf_q <= vram_rdata;
      end

      if (wr_data_ev_d) begin
        we_q    <= 1'b1;
        wdata_q <= din;
        rbuf_q  <= din;
        state_q <= ST_FIRST;
      end else if (rd_data_ev_d) begin
        re_q    <= 1'b1;
        state_q <= ST_FIRST;
      end else if (rd_stat_ev_d) begin
        state_q <= ST_FIRST;
      end else if (wr_ctrl_ev_d) begin
        case (state_q)
          ST_FIRST: begin
            latch_q <= din;
            state_q <= ST_SECOND;
          end
          ST_SECOND: begin
            if (din[7]) begin
              regs_q[din[2:0]] <= latch_q;
            end else begin
              addr_q <= {din[5:0], latch_q};
              // din[6]=0 is a read setup: prefetch from the new address.
              re_q   <= ~din[6];
            end
            state_q <= ST_FIRST;
          end
          default: begin
            state_q <= ST_FIRST;
          end
        endcase
      end
    end
  end

  vdp_status u_status (
    .clk           (clk),
    .reset         (reset),
    .frame_end     (frame_end),
    .spr_coll      (spr_coll),
    .spr_fifth     (spr_fifth),
    .spr_fifth_num (spr_fifth_num),
    .clr           (rd_stat_ev_d),
    .int_en        (regs_q[1][5]),
    .status        (status_d),
    .n_int         (n_int)
  );

  // Output mapping; dout is combinational on io_addr.
  always_comb begin
    dout       = is_ctrl_d ? status_d : rbuf_q;
    vram_addr  = addr_q;
    vram_wdata = wdata_q;
    vram_we    = we_q;
    vram_re    = re_q;
    regs       = regs_q;
  end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// tb_vdp_cpu_port -- randomized + directed bench for vdp_cpu_port.
//   A behavioural model (flat VRAM array, address counter, register array)
//   predicts every VRAM strobe into a scoreboard queue; a negedge monitor
//   pops and compares whenever the DUT raises vram_we or vram_re.
module tb_vdp_cpu_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic [7:0]  io_addr = 8'h00;
  logic        n_io_wr = 1'b1;
  logic        n_io_rd = 1'b1;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic        vram_re;
  logic [7:0]  vram_rdata = 8'h00;
  logic        vram_rvalid = 1'b0;
  logic        frame_end = 1'b0;
  logic        spr_coll = 1'b0;
  logic        spr_fifth = 1'b0;
  logic [4:0]  spr_fifth_num = 5'd0;
  logic [63:0] regs;
  logic        n_int;

  int errors = 0;
  int checks = 0;

  vdp_cpu_port dut (
    .clk           (clk),
    .reset         (reset),
    .ce            (ce),
    .io_addr       (io_addr),
    .n_io_wr       (n_io_wr),
    .n_io_rd       (n_io_rd),
    .din           (din),
    .dout          (dout),
    .vram_addr     (vram_addr),
    .vram_wdata    (vram_wdata),
    .vram_we       (vram_we),
    .vram_re       (vram_re),
    .vram_rdata    (vram_rdata),
    .vram_rvalid   (vram_rvalid),
    .frame_end     (frame_end),
    .spr_coll      (spr_coll),
    .spr_fifth     (spr_fifth),
    .spr_fifth_num (spr_fifth_num),
    .regs          (regs),
    .n_int         (n_int)
  );

  always #5 clk = ~clk;

  // Power-on VRAM contents, never zero; 0x3FFF holds 0x5A.
  function automatic logic [7:0] init_byte(input logic [13:0] a);
    if (a == 14'h3FFF) return 8'h5A;
    return (a[7:0] ^ {2'b00, a[13:8]}) | 8'h01;
  endfunction

  // VRAM responder: rvalid exactly 1 clk after vram_re.
  logic [7:0] vmem [16384];
  bit         vwritten [16384];
  always @(posedge clk) begin
    vram_rvalid <= vram_re;
    vram_rdata  <= vwritten[vram_addr] ? vmem[vram_addr] : init_byte(vram_addr);
    if (vram_we) begin
      vmem[vram_addr]     <= vram_wdata;
      vwritten[vram_addr] <= 1'b1;
    end
  end

  typedef struct {
    bit          is_wr;
    logic [13:0] addr;
    logic [7:0]  data;
  } exp_t;
  exp_t sb_q[$];

  // Scoreboard monitor for VRAM strobes.
  always @(negedge clk) begin
    if (vram_we || vram_re) begin
      exp_t e;
      checks++;
      if (vram_we && vram_re) begin
        errors++;
        $display("FAIL strobe_excl: we=%0b re=%0b, required not both", vram_we, vram_re);
      end else if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: we=%0b re=%0b addr=%h, required none", vram_we, vram_re, vram_addr);
      end else begin
        e = sb_q.pop_front();
        if (vram_we !== e.is_wr || vram_addr !== e.addr || (e.is_wr && vram_wdata !== e.data)) begin
          errors++;
          $display("FAIL vram_strobe: got we=%0b addr=%h data=%h, required we=%0b addr=%h data=%h",
                   vram_we, vram_addr, vram_wdata, e.is_wr, e.addr, e.data);
        end
      end
    end
  end

  // Reference model state.
  logic [7:0]  mmem [16384];
  bit          m_first;
  logic [7:0]  m_latch;
  logic [13:0] m_addr;
  logic [7:0]  m_rbuf;
  logic [63:0] m_regs;
  logic [7:0]  rd_tmp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // One CPU IO cycle: strobe low for one ce, then high for the next ce.
  task automatic cpu_cycle(input bit is_wr, input logic [7:0] a, input logic [7:0] d,
                           input bit coll, output logic [7:0] rd);
    @(negedge clk);
    io_addr = a;
    din = d;
    if (is_wr) n_io_wr = 1'b0; else n_io_rd = 1'b0;
    ce = 1'b1;
    spr_coll = coll;
    #1 rd = dout;
    @(negedge clk);
    ce = 1'b0;
    spr_coll = 1'b0;
    repeat (8) @(negedge clk);
    n_io_wr = 1'b1;
    n_io_rd = 1'b1;
    ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic m_prefetch();
    sb_q.push_back('{1'b0, m_addr, 8'h00});
    m_rbuf = mmem[m_addr];
    m_addr = m_addr + 14'd1;
  endtask

  task automatic do_ctrl(input logic [7:0] d);
    if (m_first) begin
      m_latch = d;
      m_first = 1'b0;
    end else begin
      m_first = 1'b1;
      if (d[7]) begin
        m_regs[d[2:0]*8 +: 8] = m_latch;
      end else begin
        m_addr = {d[5:0], m_latch};
        if (!d[6]) m_prefetch();
      end
    end
    cpu_cycle(1'b1, 8'h99, d, 1'b0, rd_tmp);
  endtask

  task automatic do_dwr(input logic [7:0] d);
    sb_q.push_back('{1'b1, m_addr, d});
    mmem[m_addr] = d;
    m_rbuf = d;
    m_addr = m_addr + 14'd1;
    m_first = 1'b1;
    cpu_cycle(1'b1, 8'h98, d, 1'b0, rd_tmp);
  endtask

  task automatic do_drd();
    logic [7:0] exp;
    exp = m_rbuf;
    m_prefetch();
    m_first = 1'b1;
    cpu_cycle(1'b0, 8'h98, 8'h00, 1'b0, rd_tmp);
    check("data_read", {56'd0, rd_tmp}, {56'd0, exp});
  endtask

  task automatic do_srd(input logic [7:0] exp, input bit coll);
    m_first = 1'b1;
    cpu_cycle(1'b0, 8'h99, 8'h00, coll, rd_tmp);
    check("status_read", {56'd0, rd_tmp}, {56'd0, exp});
  endtask

  task automatic check_state();
    check("regs", regs, m_regs);
    check("vram_addr", {50'd0, vram_addr}, {50'd0, m_addr});
  endtask

  task automatic m_reset();
    m_first = 1'b1;
    m_latch = 8'h00;
    m_addr  = 14'd0;
    m_rbuf  = 8'h00;
    m_regs  = 64'd0;
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    io_addr = 8'h98;
    #1;
    check("rst_regs", regs, 64'd0);
    check("rst_addr", {50'd0, vram_addr}, 64'd0);
    check("rst_dout", {56'd0, dout}, 64'd0);
    check("rst_nint", {63'd0, n_int}, 64'd1);
    check("rst_strobes", {62'd0, vram_we, vram_re}, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ce = 1'b0;
    n_io_wr = 1'b1;
    n_io_rd = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_reset();
  endtask

  task automatic pulse(input int which, input logic [4:0] num);
    @(negedge clk);
    case (which)
      0: frame_end = 1'b1;
      1: begin spr_fifth = 1'b1; spr_fifth_num = num; end
      default: spr_coll = 1'b1;
    endcase
    @(negedge clk);
    frame_end = 1'b0;
    spr_fifth = 1'b0;
    spr_coll = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16384; i++) mmem[i] = init_byte(14'(i));
    m_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_outputs();

    // Write setup to 0x0000, two data writes.
    do_ctrl(8'h00);
    do_ctrl(8'h40);
    do_dwr(8'hAA);
    do_dwr(8'h55);
    check("addr_after_writes", {50'd0, vram_addr}, 64'h2);

    // Register write with ignored middle bits, then a fresh first byte.
    do_ctrl(8'hF1);
    do_ctrl(8'h87);
    check("r7", {56'd0, regs[63:56]}, 64'hF1);
    do_ctrl(8'h12);
    do_ctrl(8'h82);
    check("r2", {56'd0, regs[23:16]}, 64'h12);
    check_state();

    // Read setup at the top of VRAM: prefetch then wrap.
    do_ctrl(8'hFF);
    do_ctrl(8'h3F);
    check("addr_wrap", {50'd0, vram_addr}, 64'h0);
    do_drd();
    check_state();

    // Frame interrupt and status clear.
    do_ctrl(8'h20);
    do_ctrl(8'h81);
    pulse(0, 5'd0);
    check("nint_set", {63'd0, n_int}, 64'd0);
    do_srd(8'h80, 1'b0);
    check("nint_clear", {63'd0, n_int}, 64'd1);

    // Collision pulse coinciding with the clear survives.
    do_srd(8'h00, 1'b1);
    do_srd(8'h20, 1'b0);
    do_srd(8'h00, 1'b0);

    // Fifth sprite: number kept after clear, frozen while 5S is set.
    pulse(1, 5'h13);
    do_srd(8'h53, 1'b0);
    do_srd(8'h13, 1'b0);
    pulse(1, 5'h07);
    pulse(1, 5'h0A);
    do_srd(8'h47, 1'b0);

    // Reset while a prefetch is in flight: the late rvalid is ignored.
    do_ctrl(8'h00);
    sb_q.push_back('{1'b0, 14'h1000, 8'h00});
    @(negedge clk);
    io_addr = 8'h99;
    din = 8'h10;
    n_io_wr = 1'b0;
    ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
    n_io_wr = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    repeat (4) @(negedge clk);
    check_reset_outputs();

    // Reset between control bytes: the next byte is a first byte.
    do_ctrl(8'h34);
    do_reset();
    check_reset_outputs();
    do_ctrl(8'h05);
    do_ctrl(8'h87);
    check("r7_after_reset", {56'd0, regs[63:56]}, 64'h05);
    check_state();

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0: do_dwr(8'($urandom));
        1: do_drd();
        2: begin
          do_ctrl(8'($urandom));
          do_ctrl({1'b1, 4'($urandom), 3'($urandom)});
        end
        3: begin
          do_ctrl(8'($urandom));
          do_ctrl({2'b01, 6'($urandom)});
        end
        default: begin
          do_ctrl(8'($urandom));
          do_ctrl({2'b00, 6'($urandom)});
        end
      endcase
      check_state();
    end

    repeat (4) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vdp_cpu_port.md
VDP_CPU_PORT -- requirements
Module: vdp_cpu_port

Interface
REQ-001 clk  in  1  system clock; all logic on posedge clk.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 ce  in  1  CPU clock-enable pulse, one clk wide, at least 8 clk apart.
REQ-004 io_addr  in  8  CPU address low byte.
REQ-005 n_io_wr  in  1  active-low IO write strobe (n_WR|n_IORQ).
REQ-006 n_io_rd  in  1  active-low IO read strobe (n_RD|n_IORQ).
REQ-007 din  in  8  CPU write data.
REQ-008 dout  out  8  CPU read data for ports 0x98/0x99.
REQ-009 vram_addr  out  14  VRAM address toward video block.
REQ-010 vram_wdata  out  8  VRAM write data.
REQ-011 vram_we  out  1  one-clk VRAM write strobe.
REQ-012 vram_re  out  1  one-clk VRAM read strobe.
REQ-013 vram_rdata  in  8  VRAM read data, valid when vram_rvalid.
REQ-014 vram_rvalid  in  1  asserted exactly 1 clk after vram_re.
REQ-015 frame_end  in  1  one-clk pulse at start of vertical blank.
REQ-016 spr_coll  in  1  one-clk sprite-collision pulse.
REQ-017 spr_fifth  in  1  one-clk fifth-sprite pulse; spr_fifth_num in 5 gives sprite number.
REQ-018 regs  out  64  VDP registers R0..R7, Rn at [8n+7:8n].
REQ-019 n_int  out  1  active-low interrupt.

Function
REQ-020 Access events: a write/read event occurs on a ce cycle where the strobe is low, io_addr is 0x98 or 0x99, and the strobe was high at the previous ce (one event per IO cycle).
REQ-021 Control FSM states FIRST and SECOND; a control write in FIRST latches din and moves to SECOND.
REQ-022 Control write in SECOND with din[7]=1 writes the latch into R[din[2:0]]; din[6:3] are ignored; returns to FIRST.
REQ-023 Control write in SECOND with din[7:6]=01 loads vram_addr={din[5:0],latch}; returns to FIRST.
REQ-024 Control write in SECOND with din[7:6]=00 loads the address, issues a prefetch read at it, post-increments, and returns to FIRST.
REQ-025 Any data-port access or status read forces the FSM to FIRST.
REQ-026 Data write: vram_we for one clk, 1 clk after the event, with the current address and din; read buffer <= din; address +1.
REQ-027 Data read: dout = read buffer; 1 clk after the event, prefetch issues vram_re at the current address and increments it; read buffer <= vram_rdata on vram_rvalid.
REQ-028 Address arithmetic is 14-bit; 0x3FFF+1 wraps to 0x0000.
REQ-029 Status byte is {F,5S,C,fifth_num[4:0]}; F is set by frame_end, C by spr_coll, 5S and fifth_num by spr_fifth when 5S=0.
REQ-030 Status read: dout = status; F, 5S and C clear 1 clk after the event; a set pulse in the same clk wins over the clear.
REQ-031 n_int = ~(F & R1[5]); combinational from registers.
REQ-032 dout is combinational: status when io_addr=0x99, else the read buffer.
REQ-033 vram_we and vram_re are never asserted in the same clk.

Reset
REQ-034 Reset clears R0..R7, the latch, the address, the read buffer and the status to 0; FSM goes to FIRST; vram_we=vram_re=0; n_int=1.
REQ-035 Reset during a pending prefetch cancels it; the rvalid arriving after reset is ignored.

Structure
REQ-036 Shared package vdp_pkg holds port numbers 0x98/0x99, status bit positions, VRAM address width (14) and register count (8).
REQ-037 The status flags and interrupt logic are one natural sub-module, vdp_status; all other logic sits in vdp_cpu_port.

Verification
REQ-038 Write 0x99 bytes 0x00, 0x40, then write 0x98 bytes 0xAA, 0x55 -> vram_we at addr 0x0000 with data 0xAA, then at 0x0001 with data 0x55; final addr 0x0002.
REQ-039 Write 0x99 bytes 0xF1, 0x87 -> R7=0xF1 and no VRAM strobe; next write 0x99 0x12 is taken as FIRST.
REQ-040 Write 0x99 bytes 0xFF, 0x3F (read setup), VRAM returns 0x5A -> vram_re at 0x3FFF, next addr 0x0000; read of 0x98 returns 0x5A, then a prefetch at 0x0000.
REQ-041 Set R1=0x20, pulse frame_end -> n_int=0; read 0x99 returns 0x80, then n_int=1.
REQ-042 spr_coll pulse in the same clk as the status-read clear -> C remains 1.
REQ-043 Assert reset between the first and second control byte, then write 0x99 0x05 -> it is latched as a first byte; all outputs are at reset values.
